mem_writer: RTL and testbench

//  Loads one operand vector pair for the dot-product datapath. Accepts element pairs on a

---
 rtl/mem_writer_pkg.sv | 27 ++
 rtl/mem_writer_mac.sv | 45 ++++
 rtl/mem_writer.sv | 165 ++++++++++++++++
 tb/tb_mem_writer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_writer_pkg.sv
// ---------------------------------------------------------------------------
// mem_writer_pkg
// Shared types and width helpers for the operand-memory writer.
//   state_t  : writer FSM states (IDLE, LOAD, DONE)
//   cnt_w()  : width of element_count for a given VECTOR_WIDTH
//   acc_w()  : width of the optional dot-product accumulator
// Optional feature macro used by the writer: MEM_WRITER_DOT_EN
// ---------------------------------------------------------------------------
package mem_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // element_count must be able to hold VECTOR_WIDTH itself (value after a pass)
  function automatic int cnt_w(input int vector_width);
    return $clog2(vector_width + 1);
  endfunction

  // Sum of vector_width unsigned products of two data_width operands
  function automatic int acc_w(input int data_width, input int vector_width);
    return 2 * data_width + $clog2(vector_width);
  endfunction

endpackage

// File: rtl/mem_writer_mac.sv
// ---------------------------------------------------------------------------
// mem_writer_mac
// Unsigned multiply-accumulate with synchronous clear and enable.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (acc -> 0)
//   i_clear    : zero the accumulator at the next edge (wins over i_en)
//   i_en       : add i_a*i_b at the next edge
//   i_a, i_b   : DATA_WIDTH unsigned operands
//   o_acc      : accumulator, acc_w(DATA_WIDTH, VECTOR_WIDTH) bits
// ---------------------------------------------------------------------------
module mem_writer_mac
  import mem_writer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_clear,
  input  logic                                        i_en,
  input  logic [DATA_WIDTH-1:0]                       i_a,
  input  logic [DATA_WIDTH-1:0]                       i_b,
  output logic [acc_w(DATA_WIDTH, VECTOR_WIDTH)-1:0]  o_acc
);

  localparam int ACC_W = acc_w(DATA_WIDTH, VECTOR_WIDTH);

  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_W-1:0]        r_acc;

  assign w_prod = {{DATA_WIDTH{1'b0}}, i_a} * {{DATA_WIDTH{1'b0}}, i_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mem_writer.sv
// ---------------------------------------------------------------------------
// mem_writer
// Loads one operand vector pair into two operand memories (mem1, mem2) at
// consecutive addresses starting at BASE_ADDR, then pulses writing_done so the
// downstream reader can be started.
//
// Handshake: a pair is accepted at a rising edge where in_valid && in_ready;
// in_ready is high exactly while the FSM is in LOAD, decoded from the state
// register. in_valid may drop at any time; the pass waits indefinitely.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start_writing            : begin a pass (sampled in IDLE only)
//   in_valid / in_ready      : input pair stream handshake
//   in_data1 / in_data2      : elements for mem1 / mem2
//   wr_en_mem1/2             : write strobes (identical)
//   wr_addr_mem1/2           : write addresses (identical)
//   wr_data_mem1/2           : write data
//   writing_done             : 1-cycle pulse coincident with the final write
//   busy                     : high in LOAD and DONE
//   start_err                : 1-cycle pulse, start_writing seen while busy
//   element_count            : pairs accepted in the current / last pass
//   dbg_state                : current FSM state
//   dot_result               : running sum of in_data1*in_data2 (only with
//                              MEM_WRITER_DOT_EN defined)
// ---------------------------------------------------------------------------
module mem_writer
  import mem_writer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int BASE_ADDR    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_writing,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data1,
  input  logic [DATA_WIDTH-1:0]             in_data2,
  output logic                              wr_en_mem1,
  output logic                              wr_en_mem2,
  output logic [ADDR_WIDTH-1:0]             wr_addr_mem1,
  output logic [ADDR_WIDTH-1:0]             wr_addr_mem2,
  output logic [DATA_WIDTH-1:0]             wr_data_mem1,
  output logic [DATA_WIDTH-1:0]             wr_data_mem2,
  output logic                              writing_done,
  output logic                              busy,
  output logic                              start_err,
  output logic [cnt_w(VECTOR_WIDTH)-1:0]    element_count,
  output state_t                            dbg_state
`ifdef MEM_WRITER_DOT_EN
  ,
  output logic [acc_w(DATA_WIDTH, VECTOR_WIDTH)-1:0] dot_result
`endif
);

  localparam int CNT_W = cnt_w(VECTOR_WIDTH);

  // The vector must fit in memory without the address wrapping.
  if (BASE_ADDR + VECTOR_WIDTH > DEPTH) begin : g_param_check
    $fatal(1, "mem_writer: BASE_ADDR + VECTOR_WIDTH exceeds DEPTH");
  end

  state_t                r_state;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data1;
  logic [DATA_WIDTH-1:0] r_wr_data2;
  logic                  r_done;
  logic                  r_start_err;
  logic [CNT_W-1:0]      r_count;

  logic                  w_accept;
  logic                  w_busy;
  logic                  w_start;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  assign in_ready    = (r_state == LOAD);
  assign w_busy      = (r_state == LOAD) || (r_state == DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_start     = (r_state == IDLE) && start_writing;
  assign w_last      = (r_count == CNT_W'(VECTOR_WIDTH - 1));
  assign w_next_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data1  <= '0;
      r_wr_data2  <= '0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
      r_count     <= '0;
    end else begin
      // Strobes default low; address/data hold while no write is issued.
      r_wr_en     <= 1'b0;
      r_done      <= 1'b0;
      r_start_err <= start_writing && w_busy;
      case (r_state)
        IDLE: begin
          if (start_writing) begin
            r_state <= LOAD;
            r_count <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= w_next_addr;
            r_wr_data1 <= in_data1;
            r_wr_data2 <= in_data2;
            r_count    <= r_count + 1'b1;
            if (w_last) begin
              // writing_done rides along with the final strobe in DONE.
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wr_en_mem1    = r_wr_en;
  assign wr_en_mem2    = r_wr_en;
  assign wr_addr_mem1  = r_wr_addr;
  assign wr_addr_mem2  = r_wr_addr;
  assign wr_data_mem1  = r_wr_data1;
  assign wr_data_mem2  = r_wr_data2;
  assign writing_done  = r_done;
  assign busy          = w_busy;
  assign start_err     = r_start_err;
  assign element_count = r_count;
  assign dbg_state     = r_state;

`ifdef MEM_WRITER_DOT_EN
  mem_writer_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .VECTOR_WIDTH(VECTOR_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_start),
    .i_en   (w_accept),
    .i_a    (in_data1),
    .i_b    (in_data2),
    .o_acc  (dot_result)
  );
`else
  logic w_unused;
  assign w_unused = w_start;
`endif

endmodule

// File: tb/tb_mem_writer.sv
// ---------------------------------------------------------------------------
// tb_mem_writer
// Self-checking bench for mem_writer with default parameters.
// A pass-level reference model predicts each write (address, data, last flag)
// and pushes it into exp_q; a negedge monitor pops and compares every strobe.
// Per-cycle status outputs are checked against the same model. A behavioural
// memory pair captures the writes to check the final memory image.
// Define MEM_WRITER_DOT_EN to also check dot_result.
// ---------------------------------------------------------------------------
module tb_mem_writer;
  import mem_writer_pkg::*;

  localparam int DW    = 8;
  localparam int VW    = 4;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int BASE  = 0;
  localparam int QW    = 1 + AW + 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_writing;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data1;
  logic [DW-1:0] in_data2;
  logic          wr_en_mem1;
  logic          wr_en_mem2;
  logic [AW-1:0] wr_addr_mem1;
  logic [AW-1:0] wr_addr_mem2;
  logic [DW-1:0] wr_data_mem1;
  logic [DW-1:0] wr_data_mem2;
  logic          writing_done;
  logic          busy;
  logic          start_err;
  logic [cnt_w(VW)-1:0] element_count;
  state_t        dbg_state;
`ifdef MEM_WRITER_DOT_EN
  logic [acc_w(DW, VW)-1:0] dot_result;
`endif

  mem_writer #(
    .DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .DEPTH(DEPTH),
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .start_writing(start_writing),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2),
    .wr_en_mem1(wr_en_mem1), .wr_en_mem2(wr_en_mem2),
    .wr_addr_mem1(wr_addr_mem1), .wr_addr_mem2(wr_addr_mem2),
    .wr_data_mem1(wr_data_mem1), .wr_data_mem2(wr_data_mem2),
    .writing_done(writing_done), .busy(busy), .start_err(start_err),
    .element_count(element_count), .dbg_state(dbg_state)
`ifdef MEM_WRITER_DOT_EN
    , .dot_result(dot_result)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [QW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (pass level) ----------------
  // m_phase: 0 = no pass, 1 = taking pairs, 2 = final-write cycle
  int          m_phase = 0;
  int          m_k     = 0;
  int unsigned m_sum   = 0;

  // Behavioural operand memories fed by the DUT write port.
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];
  always @(posedge clk) begin
    if (!rst && wr_en_mem1) mem1[wr_addr_mem1] <= wr_data_mem1;
    if (!rst && wr_en_mem2) mem2[wr_addr_mem2] <= wr_data_mem2;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_mem1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got write addr 0x%0h, expected no write at %0t",
                   wr_addr_mem1, $time);
        end else begin
          logic [QW-1:0] e;
          e = exp_q.pop_front();
          chk("wr_en_mem2",   wr_en_mem2,   1);
          chk("wr_addr_mem1", wr_addr_mem1, e[2*DW +: AW]);
          chk("wr_addr_mem2", wr_addr_mem2, e[2*DW +: AW]);
          chk("wr_data_mem1", wr_data_mem1, e[DW +: DW]);
          chk("wr_data_mem2", wr_data_mem2, e[0 +: DW]);
          chk("writing_done", writing_done, e[QW-1]);
        end
      end else begin
        chk("wr_en_mem2_idle",   wr_en_mem2,   0);
        chk("writing_done_idle", writing_done, 0);
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a falling edge; drives one cycle and advances the model.
  task automatic cycle(input logic sw, input logic v, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2);
    logic serr;
    state_t exp_st;
    start_writing = sw;
    in_valid      = v;
    in_data1      = d1;
    in_data2      = d2;
    #1;
    exp_st = (m_phase == 0) ? IDLE : (m_phase == 1) ? LOAD : DONE;
    chk("in_ready",  in_ready,  m_phase == 1);
    chk("busy",      busy,      m_phase != 0);
    chk("dbg_state", dbg_state, exp_st);
    serr = sw && (m_phase != 0);
    if (m_phase == 0) begin
      if (sw) begin
        m_phase = 1;
        m_k     = 0;
        m_sum   = 0;
      end
    end else if (m_phase == 1) begin
      if (v) begin
        exp_q.push_back({(m_k == VW - 1), AW'(BASE + m_k), d1, d2});
        m_sum += d1 * d2;
        m_k++;
        if (m_k == VW) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("start_err",     start_err,     serr);
    chk("element_count", element_count, m_k);
`ifdef MEM_WRITER_DOT_EN
    chk("dot_result",    dot_result,    m_sum);
`endif
  endtask

  task automatic check_image(input string name);
    for (int i = 0; i < VW; i++) begin
      chk({name, "_mem1"}, mem1[BASE + i], 11 + i);
      chk({name, "_mem2"}, mem2[BASE + i], 21 + i);
    end
  endtask

  task automatic check_all_zero();
    chk("rst_wr_en1",   wr_en_mem1,    0);
    chk("rst_wr_en2",   wr_en_mem2,    0);
    chk("rst_addr1",    wr_addr_mem1,  0);
    chk("rst_addr2",    wr_addr_mem2,  0);
    chk("rst_data1",    wr_data_mem1,  0);
    chk("rst_data2",    wr_data_mem2,  0);
    chk("rst_done",     writing_done,  0);
    chk("rst_serr",     start_err,     0);
    chk("rst_count",    element_count, 0);
    chk("rst_ready",    in_ready,      0);
    chk("rst_busy",     busy,          0);
`ifdef MEM_WRITER_DOT_EN
    chk("rst_dot",      dot_result,    0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start_writing = 1'b0;
    in_valid = 1'b0;
    in_data1 = '0;
    in_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    #1;
    check_all_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // T1 basic pass
    cycle(1, 0, 0, 0);
    for (int i = 0; i < VW; i++) cycle(0, 1, DW'(11 + i), DW'(21 + i));
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_image("t1");

    // T2 stall after pair 2 (memory cleared first so the image is rebuilt)
    for (int i = 0; i < DEPTH; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 1, DW'(11 + i), DW'(21 + i));
    for (int i = 0; i < 3; i++) cycle(0, 0, DW'($urandom), DW'($urandom));
    for (int i = 2; i < VW; i++) cycle(0, 1, DW'(11 + i), DW'(21 + i));
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_image("t2");

    // T3 stray start during LOAD and during the final-write cycle
    cycle(1, 0, 0, 0);
    cycle(0, 1, 8'd31, 8'd41);
    cycle(1, 1, 8'd32, 8'd42);
    cycle(0, 1, 8'd33, 8'd43);
    cycle(0, 1, 8'd34, 8'd44);
    cycle(1, 1, 8'd99, 8'd99);
    cycle(0, 0, 0, 0);

    // T4 in_valid while idle
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'hAA, 8'hAA);

    // T5 reset after two accepts
    cycle(1, 0, 0, 0);
    cycle(0, 1, 8'd5, 8'd6);
    cycle(0, 1, 8'd7, 8'd8);
    chk("queue_before_rst", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check_all_zero();
    m_phase = 0;
    m_k     = 0;
    m_sum   = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < VW; i++) cycle(0, 1, DW'(11 + i), DW'(21 + i));
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_image("t5");

    // Randomized passes: random stalls, random stray starts, random data
    for (int p = 0; p < 25; p++) begin
      int guard;
      guard = 0;
      for (int i = 0; i < $urandom_range(0, 2); i++)
        cycle(0, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
      cycle(1, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
      while (m_phase != 0 && guard < 100) begin
        cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
              DW'($urandom), DW'($urandom));
        guard++;
      end
      if (guard >= 100) begin
        n_cmp++;
        n_err++;
        $display("FAIL pass_budget: got no pass end in %0d cycles, expected end of pass", guard);
      end
    end

    repeat (3) cycle(0, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
